plru_update_ctrl: RTL and testbench

- Tree pseudo-LRU replacement controller for the set-associative cache.
- Accepts one access per cycle from the tag-compare stage and reads the set's PLRU bits through port 0 of the dual-port LRU array.
- Returns the hit way or chosen victim way, then writes the updated tree bits through port 1.
- Owns a flush sequencer that clears every set's tree bits on request.

---
 rtl/cache_pkg.sv | 47 ++++
 rtl/plru_flush_seq.sv | 74 +++++++
 rtl/plru_update_ctrl.sv | 162 ++++++++++++++++
 tb/tb_plru_update_ctrl.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared PLRU defaults, types and tree helpers for the cache controllers
package cache_pkg;

  localparam int WAYS_DEF    = 4;
  localparam int S_INDEX_DEF = 4;
  localparam int WAY_W       = $clog2(WAYS_DEF);

  typedef logic [WAYS_DEF-2:0] plru_t;
  typedef logic [WAY_W-1:0]    way_idx_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    FLUSH = 2'd2
  } flush_state_t;

  // Node i has children 2i+1 / 2i+2; a 0 bit steers the victim walk left.
  function automatic way_idx_t plru_victim(plru_t tree);
    way_idx_t way;
    way_idx_t node;
    way  = '0;
    node = '0;
    for (int lvl = 0; lvl < WAY_W; lvl++) begin
      way  = way_idx_t'({way, tree[node]});
      node = way_idx_t'(32'(node) * 2 + 32'd1 + 32'(tree[node]));
    end
    return way;
  endfunction

  function automatic plru_t plru_update(plru_t tree, way_idx_t way);
    plru_t    t;
    way_idx_t node;
    way_idx_t w;
    logic     bit_v;
    t    = tree;
    node = '0;
    w    = way;
    for (int lvl = 0; lvl < WAY_W; lvl++) begin
      bit_v   = w[WAY_W-1];
      w       = way_idx_t'({w, 1'b0});
      t[node] = ~bit_v;
      node    = way_idx_t'(32'(node) * 2 + 32'd1 + 32'(bit_v));
    end
    return t;
  endfunction

endpackage

// File: rtl/plru_flush_seq.sv
// rtl/plru_flush_seq.sv - flush FSM and set counter; owns array port 1 while clearing
module plru_flush_seq
  import cache_pkg::*;
#(
  parameter int S_INDEX = S_INDEX_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush_req,
  output logic               flush_busy,
  output logic               accept_en,
  output logic               flush_start,
  output logic               flush_we,
  output logic [S_INDEX-1:0] flush_addr
);

  flush_state_t       r_state;
  flush_state_t       w_state_nxt;
  logic [S_INDEX-1:0] r_cnt;
  logic [S_INDEX-1:0] w_cnt_nxt;
  logic               r_live;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_live  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_live  <= 1'b1;
    end
  end

  // A flush request wins over a same-cycle access, so the pipeline only has
  // the already-accepted stage-1 entry to retire during DRAIN.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    flush_busy  = 1'b0;
    accept_en   = 1'b0;
    flush_start = 1'b0;
    flush_we    = 1'b0;
    flush_addr  = '0;
    case (r_state)
      IDLE: begin
        if (r_live && flush_req) begin
          flush_start = 1'b1;
          w_state_nxt = DRAIN;
        end else begin
          accept_en = r_live;
        end
      end
      DRAIN: begin
        flush_busy  = 1'b1;
        w_cnt_nxt   = '0;
        w_state_nxt = FLUSH;
      end
      FLUSH: begin
        flush_busy = 1'b1;
        flush_we   = 1'b1;
        flush_addr = r_cnt;
        w_cnt_nxt  = r_cnt + 1'b1;
        if (&r_cnt) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: rtl/plru_update_ctrl.sv
// rtl/plru_update_ctrl.sv - tree PLRU hit/victim selection and update with flush sequencer
// Optional hit/miss counters are enabled by defining PLRU_PERF_CNT_EN.
module plru_update_ctrl
  import cache_pkg::*;
#(
  parameter int S_INDEX = S_INDEX_DEF,
  parameter int WAYS    = WAYS_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [S_INDEX-1:0]        req_set,
  input  logic                      req_hit,
  input  logic [$clog2(WAYS)-1:0]   req_way,
  input  logic [WAYS-1:0]           req_vmask,
  output logic                      rsp_valid,
  output logic [$clog2(WAYS)-1:0]   rsp_way,
  input  logic                      flush_req,
  output logic                      flush_busy,
`ifdef PLRU_PERF_CNT_EN
  output logic [31:0]               hit_cnt,
  output logic [31:0]               miss_cnt,
`endif
  output logic                      lru_csb0,
  output logic                      lru_web0,
  output logic [S_INDEX-1:0]        lru_addr0,
  input  logic [WAYS-2:0]           lru_dout0,
  output logic                      lru_csb1,
  output logic                      lru_web1,
  output logic [S_INDEX-1:0]        lru_addr1,
  output logic [WAYS-2:0]           lru_din1
);

  localparam int WIDTH = WAYS - 1;

  logic               w_accept_en;
  logic               w_flush_start;
  logic               w_flush_we;
  logic [S_INDEX-1:0] w_flush_addr;
  logic               w_accept;

  logic               r_s1_valid;
  logic [S_INDEX-1:0] r_s1_set;
  logic               r_s1_hit;
  way_idx_t           r_s1_way;
  logic [WAYS-1:0]    r_s1_vmask;

  plru_t              w_tree;
  logic               w_inv_found;
  way_idx_t           w_inv_way;
  way_idx_t           w_sel;
  logic               w_s1_live;
  logic [WIDTH-1:0]   w_s1_din;

  plru_flush_seq #(
    .S_INDEX (S_INDEX)
  ) u_flush_seq (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush_req   (flush_req),
    .flush_busy  (flush_busy),
    .accept_en   (w_accept_en),
    .flush_start (w_flush_start),
    .flush_we    (w_flush_we),
    .flush_addr  (w_flush_addr)
  );

  assign req_ready = w_accept_en;
  assign w_accept  = req_valid && w_accept_en;
  assign lru_csb0  = !w_accept;
  assign lru_web0  = 1'b1;
  assign lru_addr0 = w_accept ? req_set : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_set   <= '0;
      r_s1_hit   <= 1'b0;
      r_s1_way   <= '0;
      r_s1_vmask <= '0;
    end else begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_set   <= req_set;
        r_s1_hit   <= req_hit;
        r_s1_way   <= way_idx_t'(req_way);
        r_s1_vmask <= req_vmask;
      end
    end
  end

  // Same-set back-to-back accesses rely on the array forwarding port 1 to port 0.
  assign w_tree = plru_t'(lru_dout0);

  always_comb begin
    w_inv_found = 1'b0;
    w_inv_way   = '0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (!r_s1_vmask[i]) begin
        w_inv_found = 1'b1;
        w_inv_way   = way_idx_t'(i);
      end
    end
  end

  always_comb begin
    if (r_s1_hit) begin
      w_sel = r_s1_way;
    end else if (w_inv_found) begin
      w_sel = w_inv_way;
    end else begin
      w_sel = plru_victim(w_tree);
    end
  end

  // An asserted reset swallows the stage-1 entry so no response or write escapes.
  assign w_s1_live = r_s1_valid && rst_n;
  assign w_s1_din  = plru_update(w_tree, w_sel);
  assign rsp_valid = w_s1_live;
  assign rsp_way   = w_s1_live ? w_sel : '0;

  always_comb begin
    lru_csb1  = 1'b1;
    lru_web1  = 1'b1;
    lru_addr1 = '0;
    lru_din1  = '0;
    if (w_flush_we) begin
      lru_csb1  = 1'b0;
      lru_web1  = 1'b0;
      lru_addr1 = w_flush_addr;
    end else if (w_s1_live) begin
      lru_csb1  = 1'b0;
      lru_web1  = 1'b0;
      lru_addr1 = r_s1_set;
      lru_din1  = w_s1_din;
    end
  end

`ifdef PLRU_PERF_CNT_EN
  logic [31:0] r_hit_cnt;
  logic [31:0] r_miss_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n || w_flush_start) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else if (w_s1_live) begin
      if (r_s1_hit && !(&r_hit_cnt)) begin
        r_hit_cnt <= r_hit_cnt + 32'd1;
      end
      if (!r_s1_hit && !(&r_miss_cnt)) begin
        r_miss_cnt <= r_miss_cnt + 32'd1;
      end
    end
  end

  assign hit_cnt  = r_hit_cnt;
  assign miss_cnt = r_miss_cnt;
`endif

endmodule

// File: tb/tb_plru_update_ctrl.sv
// tb/tb_plru_update_ctrl.sv - scoreboard bench for plru_update_ctrl with an array model
`timescale 1ns/1ps
module tb_plru_update_ctrl;

  localparam int S_INDEX  = 4;
  localparam int WAYS     = 4;
  localparam int NUM_SETS = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid;
  logic       req_ready;
  logic [3:0] req_set;
  logic       req_hit;
  logic [1:0] req_way;
  logic [3:0] req_vmask;
  logic       rsp_valid;
  logic [1:0] rsp_way;
  logic       flush_req;
  logic       flush_busy;
  logic       lru_csb0, lru_web0, lru_csb1, lru_web1;
  logic [3:0] lru_addr0, lru_addr1;
  logic [2:0] lru_dout0, lru_din1;
`ifdef PLRU_PERF_CNT_EN
  logic [31:0] hit_cnt, miss_cnt;
`endif

  always #5 clk = ~clk;

  plru_update_ctrl #(.S_INDEX(S_INDEX), .WAYS(WAYS)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_set    (req_set),
    .req_hit    (req_hit),
    .req_way    (req_way),
    .req_vmask  (req_vmask),
    .rsp_valid  (rsp_valid),
    .rsp_way    (rsp_way),
    .flush_req  (flush_req),
    .flush_busy (flush_busy),
`ifdef PLRU_PERF_CNT_EN
    .hit_cnt    (hit_cnt),
    .miss_cnt   (miss_cnt),
`endif
    .lru_csb0   (lru_csb0),
    .lru_web0   (lru_web0),
    .lru_addr0  (lru_addr0),
    .lru_dout0  (lru_dout0),
    .lru_csb1   (lru_csb1),
    .lru_web1   (lru_web1),
    .lru_addr1  (lru_addr1),
    .lru_din1   (lru_din1)
  );

  // Dual-port array with write-to-read forwarding
  logic [2:0] mem [NUM_SETS];
  initial begin
    for (int i = 0; i < NUM_SETS; i++) mem[i] = '0;
    lru_dout0 = '0;
  end
  always @(posedge clk) begin
    if (!lru_csb0)
      lru_dout0 <= (!lru_csb1 && !lru_web1 && lru_addr1 == lru_addr0) ? lru_din1 : mem[lru_addr0];
    if (!lru_csb1 && !lru_web1)
      mem[lru_addr1] <= lru_din1;
  end

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: tree bits per set, walked as halving way ranges
  logic [2:0] mtree [NUM_SETS];
  int m_hits = 0;
  int m_misses = 0;

  function automatic int m_victim(logic [2:0] t);
    int lo, hi, node, mid;
    lo = 0; hi = WAYS; node = 0;
    while (hi - lo > 1) begin
      mid = (lo + hi) / 2;
      if (t[node] == 1'b0) begin hi = mid; node = 2 * node + 1; end
      else begin lo = mid; node = 2 * node + 2; end
    end
    return lo;
  endfunction

  function automatic logic [2:0] m_update(logic [2:0] t, int w);
    int lo, hi, node, mid;
    lo = 0; hi = WAYS; node = 0;
    while (hi - lo > 1) begin
      mid = (lo + hi) / 2;
      if (w < mid) begin t[node] = 1'b1; hi = mid; node = 2 * node + 1; end
      else begin t[node] = 1'b0; lo = mid; node = 2 * node + 2; end
    end
    return t;
  endfunction

  function automatic int m_choose(int set, bit hit, int way, logic [3:0] vm);
    if (hit) return way;
    for (int i = 0; i < WAYS; i++) if (!vm[i]) return i;
    return m_victim(mtree[set]);
  endfunction

  typedef struct {
    int         cyc;
    int         way;
    int         set;
    logic [2:0] din;
  } exp_t;
  exp_t q[$];

  // Monitor
  always @(negedge clk) begin
    exp_t e;
    if (rsp_valid === 1'b1) begin
      if (q.size() == 0) begin
        check("unexpected_rsp", 32'(rsp_valid), 0);
      end else begin
        e = q.pop_front();
        check("rsp_cycle", cyc, e.cyc);
        check("rsp_way", 32'(rsp_way), e.way);
        check("wr_addr", 32'(lru_addr1), e.set);
        check("wr_data", 32'(lru_din1), 32'(e.din));
        check("wr_strobe", 32'({lru_csb1, lru_web1}), 0);
      end
    end else if (q.size() != 0 && q[0].cyc <= cyc) begin
      check("missing_rsp", 32'(rsp_valid), 1);
      void'(q.pop_front());
    end
  end

  task automatic drive(input bit v, input int set, input bit hit, input int way,
                       input logic [3:0] vm);
    exp_t e;
    int   w;
    req_valid = v; req_set = 4'(set); req_hit = hit; req_way = 2'(way); req_vmask = vm;
    #1;
    if (v && req_ready) begin
      w = m_choose(set, hit, way, vm);
      e.cyc = cyc + 1; e.way = w; e.set = set; e.din = m_update(mtree[set], w);
      mtree[set] = e.din;
      q.push_back(e);
      if (hit) m_hits++; else m_misses++;
    end
    @(negedge clk);
  endtask

  task automatic random_phase(input int n);
    for (int k = 0; k < n; k++) begin
      drive($urandom_range(0, 3) != 0,
            ($urandom_range(0, 1) != 0) ? $urandom_range(0, 3) : $urandom_range(0, NUM_SETS - 1),
            $urandom_range(0, 1) != 0, $urandom_range(0, WAYS - 1),
            ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'hF);
    end
  endtask

  initial begin
    int  wcnt;
    bit  found;
    for (int i = 0; i < NUM_SETS; i++) mtree[i] = '0;
    rst_n = 1'b0; req_valid = 1'b1; req_set = 4'd3; req_hit = 1'b0; req_way = '0;
    req_vmask = 4'hF; flush_req = 1'b0;
    repeat (3) @(negedge clk);

    check("rst_req_ready", 32'(req_ready), 0);
    check("rst_rsp_valid", 32'(rsp_valid), 0);
    check("rst_rsp_way", 32'(rsp_way), 0);
    check("rst_flush_busy", 32'(flush_busy), 0);
    check("rst_csb0", 32'(lru_csb0), 1);
    check("rst_web0", 32'(lru_web0), 1);
    check("rst_csb1_web1", 32'({lru_csb1, lru_web1}), 3);
    check("rst_addr_data", 32'({lru_addr0, lru_addr1, lru_din1}), 0);
    rst_n = 1'b1; req_valid = 1'b0;
    @(negedge clk);
    check("ready_after_reset", 32'(req_ready), 1);

    // Directed cases
    drive(1, 3, 0, 0, 4'b1111);
    drive(1, 5, 1, 2, 4'b1111);
    drive(1, 1, 0, 0, 4'b1011);
    for (int k = 0; k < 4; k++) drive(1, 7, 0, 0, 4'b1111);
    drive(0, 0, 0, 0, 4'hF);

    random_phase(400);

    // Full flush with set 2 dirtied first
    drive(1, 2, 1, 0, 4'hF);
    drive(0, 0, 0, 0, 4'hF);
    req_valid = 1'b1; req_set = 4'd2; flush_req = 1'b1;
    #1;
    check("ready_on_flush_req", 32'(req_ready), 0);
    @(negedge clk);
    flush_req = 1'b0; req_valid = 1'b0;
    m_hits = 0; m_misses = 0;
    wcnt = 0;
    for (int k = 0; k < NUM_SETS + 1; k++) begin
      check("flush_ready_low", 32'(req_ready), 0);
      check("flush_busy_high", 32'(flush_busy), 1);
      check("flush_no_port0", 32'(lru_csb0), 1);
      if (!lru_csb1 && !lru_web1) begin
        check("flush_addr", 32'(lru_addr1), wcnt);
        check("flush_din", 32'(lru_din1), 0);
        wcnt++;
      end
      @(negedge clk);
    end
    check("flush_write_count", wcnt, NUM_SETS);
    check("flush_busy_done", 32'(flush_busy), 0);
    check("ready_after_flush", 32'(req_ready), 1);
    for (int i = 0; i < NUM_SETS; i++) mtree[i] = '0;
    drive(1, 2, 0, 0, 4'hF);

    random_phase(150);
    drive(0, 0, 0, 0, 4'hF);

    // Reset during the write of set 6
    flush_req = 1'b1;
    @(negedge clk);
    flush_req = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      if (!lru_csb1 && !lru_web1 && lru_addr1 == 4'd6) begin
        found = 1'b1;
        rst_n = 1'b0;
      end
      @(negedge clk);
    end
    check("flush_write6_seen", 32'(found), 1);
    check("abort_busy_low", 32'(flush_busy), 0);
    for (int k = 0; k < 3; k++) begin
      check("abort_no_write", 32'(lru_csb1), 1);
      check("abort_ready_low", 32'(req_ready), 0);
      @(negedge clk);
    end
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_abort", 32'(req_ready), 1);
    check("busy_after_abort", 32'(flush_busy), 0);
    for (int i = 0; i <= 6; i++) mtree[i] = '0;
    m_hits = 0; m_misses = 0;

    random_phase(200);
    repeat (3) drive(0, 0, 0, 0, 4'hF);
    check("scoreboard_drained", q.size(), 0);
`ifdef PLRU_PERF_CNT_EN
    check("hit_cnt", hit_cnt, m_hits);
    check("miss_cnt", miss_cnt, m_misses);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
